// File: rtl/lab2_proc_proc_decode_imm_ctrl.sv
// Decode-stage immediate classifier with a 2-entry output FIFO toward X.
// Each instruction is classified on enqueue; dequeued work is tallied in counters.
module lab2_proc_proc_decode_imm_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [31:0] in_inst,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [31:0] out_inst,
  output logic [2:0]  out_imm_type,
  output logic        out_has_imm,
  output logic        out_illegal,
  input  logic        squash,
  output logic [15:0] num_insts,
  output logic [7:0]  num_illegal
);

  localparam logic [2:0] IMM_I     = 3'd0;
  localparam logic [2:0] IMM_S     = 3'd1;
  localparam logic [2:0] IMM_B     = 3'd2;
  localparam logic [2:0] IMM_U     = 3'd3;
  localparam logic [2:0] IMM_J     = 3'd4;
  localparam logic [2:0] IMM_SHAMT = 3'd5;

  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [31:0] inst_q [2];
  logic [2:0]  type_q [2];
  logic [1:0]  has_imm_q;
  logic [1:0]  illegal_q;

  logic        enq;
  logic        deq;
  logic [2:0]  enq_type;
  logic        enq_has_imm;
  logic        enq_illegal;

  always_comb begin
    enq_type    = IMM_I;
    enq_has_imm = 1'b1;
    enq_illegal = 1'b0;
    case (in_inst[6:0])
      7'b0110111, 7'b0010111:            enq_type = IMM_U;
      7'b1101111:                        enq_type = IMM_J;
      7'b1100011:                        enq_type = IMM_B;
      7'b0100011:                        enq_type = IMM_S;
      7'b0000011, 7'b1100111, 7'b1110011: enq_type = IMM_I;
      7'b0010011: begin
        if (in_inst[14:12] == 3'b001 || in_inst[14:12] == 3'b101)
          enq_type = IMM_SHAMT;
      end
      7'b0110011:                        enq_has_imm = 1'b0;
      default: begin
        enq_has_imm = 1'b0;
        enq_illegal = 1'b1;
      end
    endcase
  end

  // No enqueue-on-dequeue bypass: readiness depends only on occupancy.
  assign in_rdy  = !reset && (count != 2'd2) && !squash;
  assign out_val = !reset && (count != 2'd0);
  assign enq     = in_val && in_rdy;
  assign deq     = out_val && out_rdy && !squash;

  assign out_inst     = out_val ? inst_q[rd_ptr]    : 32'd0;
  assign out_imm_type = out_val ? type_q[rd_ptr]    : 3'd0;
  assign out_has_imm  = out_val && has_imm_q[rd_ptr];
  assign out_illegal  = out_val && illegal_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      num_insts   <= 16'd0;
      num_illegal <= 8'd0;
    end else if (squash) begin
      // Pointers realign so the next enqueue lands at the head slot.
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (enq) wr_ptr <= ~wr_ptr;
      if (deq) begin
        rd_ptr <= ~rd_ptr;
        if (illegal_q[rd_ptr]) begin
          if (num_illegal != 8'hFF) num_illegal <= num_illegal + 8'd1;
        end else begin
          num_insts <= num_insts + 16'd1;
        end
      end
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      inst_q[wr_ptr]    <= in_inst;
      type_q[wr_ptr]    <= enq_type;
      has_imm_q[wr_ptr] <= enq_has_imm;
      illegal_q[wr_ptr] <= enq_illegal;
    end
  end

endmodule

// File: tb/tb_lab2_proc_proc_decode_imm_ctrl.sv
// Directed bench: a queue scoreboard predicts FIFO contents, class fields and counters.
module tb_lab2_proc_proc_decode_imm_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_val = 1'b0;
  logic        in_rdy;
  logic [31:0] in_inst = 32'd0;
  logic        out_val;
  logic        out_rdy = 1'b0;
  logic [31:0] out_inst;
  logic [2:0]  out_imm_type;
  logic        out_has_imm;
  logic        out_illegal;
  logic        squash = 1'b0;
  logic [15:0] num_insts;
  logic [7:0]  num_illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  ty;
    logic        has_imm;
    logic        illegal;
  } entry_t;

  entry_t      sb[$];
  logic [15:0] m_insts = 16'd0;
  logic [7:0]  m_ill = 8'd0;

  lab2_proc_proc_decode_imm_ctrl dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_inst(in_inst),
    .out_val(out_val), .out_rdy(out_rdy), .out_inst(out_inst),
    .out_imm_type(out_imm_type), .out_has_imm(out_has_imm), .out_illegal(out_illegal),
    .squash(squash), .num_insts(num_insts), .num_illegal(num_illegal)
  );

  always #5 clk = ~clk;

  function automatic entry_t classify(input logic [31:0] inst);
    entry_t e;
    e.inst = inst; e.ty = 3'd0; e.has_imm = 1'b1; e.illegal = 1'b0;
    case (inst[6:0])
      7'h37, 7'h17: e.ty = 3'd3;
      7'h6F:        e.ty = 3'd4;
      7'h63:        e.ty = 3'd2;
      7'h23:        e.ty = 3'd1;
      7'h03, 7'h67, 7'h73: e.ty = 3'd0;
      7'h13:        e.ty = (inst[13:12] == 2'b01) ? 3'd5 : 3'd0;
      7'h33:        e.has_imm = 1'b0;
      default: begin e.has_imm = 1'b0; e.illegal = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge: drive, check, then advance one clock.
  task automatic cycle(input logic v, input logic [31:0] inst, input logic ordy, input logic sq);
    bit do_enq, do_deq;
    entry_t h;
    in_val = v; in_inst = inst; out_rdy = ordy; squash = sq;
    #1;
    chk("out_val", out_val, sb.size() > 0);
    chk("in_rdy", in_rdy, (sb.size() < 2) && !sq);
    if (sb.size() > 0) begin
      h = sb[0];
      chk("out_inst", out_inst, h.inst);
      chk("imm_type", out_imm_type, h.ty);
      chk("has_imm", out_has_imm, h.has_imm);
      chk("illegal", out_illegal, h.illegal);
    end else begin
      chk("idle_fields", {out_imm_type, out_has_imm, out_illegal}, 0);
    end
    chk("num_insts", num_insts, m_insts);
    chk("num_illegal", num_illegal, m_ill);
    do_deq = (sb.size() > 0) && ordy && !sq;
    do_enq = v && (sb.size() < 2) && !sq;
    @(posedge clk);
    if (sq) sb.delete();
    else begin
      if (do_deq) begin
        h = sb.pop_front();
        if (h.illegal) begin if (m_ill != 8'hFF) m_ill++; end
        else m_insts++;
      end
      if (do_enq) sb.push_back(classify(inst));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; squash = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_val", out_val, 0);
    @(posedge clk);
    sb.delete(); m_insts = 16'd0; m_ill = 8'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // addi with consumer ready
    cycle(1, 32'h00500093, 1, 0);
    cycle(0, 32'h0, 1, 0);
    cycle(0, 32'h0, 1, 0);
    chk("addi_count", num_insts, 16'd1);

    // slli, jal, sb with consumer stalled: sb refused while full
    cycle(1, 32'h00209093, 0, 0);
    cycle(1, 32'h008000EF, 0, 0);
    cycle(1, 32'h00000023, 0, 0);
    cycle(1, 32'h00000023, 0, 0);
    // full + out_rdy: dequeue only, then sb enters
    cycle(1, 32'h00000023, 1, 0);
    cycle(1, 32'h00000023, 0, 0);
    cycle(0, 32'h0, 1, 0);
    cycle(0, 32'h0, 1, 0);
    cycle(0, 32'h0, 1, 0);

    // 10 back-to-back mixed instructions exercising pointer wrap
    for (int i = 0; i < 10; i++) begin
      logic [31:0] pool [5];
      pool[0] = 32'h000000B7; pool[1] = 32'h00000063; pool[2] = 32'h002081B3;
      pool[3] = 32'h0050D093; pool[4] = 32'h00002003;
      cycle(1, pool[i % 5] | (32'(i) << 20), 1, 0);
    end
    cycle(0, 32'h0, 1, 0);

    // squash with two held and an incoming instruction
    cycle(1, 32'h00000017, 0, 0);
    cycle(1, 32'h00000067, 0, 0);
    cycle(1, 32'h00000073, 1, 1);
    cycle(0, 32'h0, 1, 0);
    cycle(1, 32'h00001013, 1, 0);
    cycle(0, 32'h0, 1, 0);

    // illegal saturation
    for (int i = 0; i < 300; i++) cycle(1, 32'hFFFFFFFF, 1, 0);
    cycle(0, 32'h0, 1, 0);
    chk("sat_ill", num_illegal, 8'hFF);

    // reset mid-operation with two entries held
    cycle(1, 32'h00500093, 0, 0);
    cycle(1, 32'hFFFFFFFF, 0, 0);
    in_val = 1'b1; out_rdy = 1'b1; in_inst = 32'h00500093;
    do_reset();
    in_val = 1'b0;
    cycle(0, 32'h0, 1, 0);
    cycle(1, 32'h0000006F, 1, 0);
    cycle(0, 32'h0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
